i2s_mic_rx: RTL and testbench

- Upstream audio front end for the spectrogram display pipeline.
- Masters an I2S MEMS microphone: generates SCK/WS from the 90 MHz system clock and deserialises one 24-bit channel.
- Delivers an 18-bit signed sample plus a one-cycle ready strobe in the exact ADATA0/ADATARDY format consumed by the VGA spectrogram stage's audio buffer writer.

---
 rtl/i2s_mic_rx.sv | 174 +++++++++++++++++
 tb/tb_i2s_mic_rx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_mic_rx.sv
// I2S MEMS microphone master: SCK/WS generation, 24-bit capture of one slot,
// 18-bit truncated sample out. Optional DC blocker: define I2S_DCBLOCK_EN.
module i2s_mic_rx #(
  parameter int SCK_DIV  = 22,
  parameter int CHANNEL  = 0,
  parameter int DC_SHIFT = 10
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic               I2S_SD,
  output logic               I2S_SCK,
  output logic               I2S_WS,
  output logic signed [17:0] ADATA0,
  output logic               ADATARDY
);
  // ADATARDY is a valid-only strobe (no ready): ADATA0 is valid in the strobe
  // cycle and the consumer must take it then; ADATA0 holds until the next strobe.

  localparam int            DW      = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCK_DIV - 1);
  localparam logic          CH_BIT  = (CHANNEL != 0);

  if (DC_SHIFT < 1 || DC_SHIFT > 24) begin : g_bad_dc_shift
    $error("DC_SHIFT must be in 1..24");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            active;
  logic [DW-1:0]   div;
  logic [5:0]      bitcnt;
  logic [5:0]      bitcnt_inc;
  logic [4:0]      slot;
  logic            sd_meta;
  logic            sd_sync;
  logic [23:0]     shift;
  logic [23:0]     shift_nxt;
  logic            div_wrap;
  logic            sample_pt;
  logic            frame_end;
  logic            capture;
  logic            last_bit;

  assign bitcnt_inc = bitcnt + 6'd1;
  assign slot       = bitcnt[4:0];
  assign shift_nxt  = {shift[22:0], sd_sync};
  assign div_wrap   = (div == DIV_MAX);
  // Sample on the last CLK of the SCK-high half, far from the mic's SD change.
  assign sample_pt  = active && I2S_SCK && div_wrap;
  assign frame_end  = sample_pt && (bitcnt == 6'd63);
  assign capture    = sample_pt && (bitcnt[5] == CH_BIT) &&
                      (slot >= 5'd1) && (slot <= 5'd24);
  assign last_bit   = capture && (slot == 5'd24);

  always_ff @(posedge CLK) begin
    if (RST) state <= EN ? ST_RUN : ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (EN) state_nxt = ST_RUN;
      ST_RUN:   if (!EN) state_nxt = frame_end ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (EN)             state_nxt = ST_RUN;
        else if (frame_end) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    active = (state != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sd_meta <= 1'b0;
      sd_sync <= 1'b0;
      div     <= '0;
      bitcnt  <= '0;
      I2S_SCK <= 1'b0;
      I2S_WS  <= 1'b0;
      shift   <= '0;
    end else begin
      sd_meta <= I2S_SD;
      sd_sync <= sd_meta;
      if (!active) begin
        div     <= '0;
        bitcnt  <= '0;
        I2S_SCK <= 1'b0;
        I2S_WS  <= 1'b0;
      end else begin
        if (div_wrap) begin
          div     <= '0;
          I2S_SCK <= ~I2S_SCK;
          // WS follows bitcnt[5] on the SCK falling toggle only.
          if (I2S_SCK) begin
            bitcnt <= bitcnt_inc;
            I2S_WS <= bitcnt_inc[5];
          end
        end else begin
          div <= div + DW'(1);
        end
        if (capture) shift <= shift_nxt;
      end
    end
  end

`ifdef I2S_DCBLOCK_EN
  localparam int YW = 18 + DC_SHIFT;
  localparam int AW = YW + 2;

  logic                 idle_entry;
  logic                 raw_v;
  logic signed [17:0]   raw;
  logic signed [17:0]   x_prev;
  logic signed [YW-1:0] y_prev;
  logic signed [YW-1:0] y_sat;
  logic signed [AW-1:0] acc;

  assign idle_entry = active && (state_nxt == ST_IDLE);

  // y keeps DC_SHIFT fractional bits so the leak term does not stall at small values.
  always_comb begin
    acc = ((AW'(raw) - AW'(x_prev)) <<< DC_SHIFT) + AW'(y_prev) - AW'(y_prev >>> DC_SHIFT);
    if (acc[AW-1:YW-1] == {(AW-YW+1){acc[AW-1]}}) y_sat = acc[YW-1:0];
    else y_sat = acc[AW-1] ? {1'b1, {(YW-1){1'b0}}} : {1'b0, {(YW-1){1'b1}}};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      raw_v    <= 1'b0;
      raw      <= '0;
      x_prev   <= '0;
      y_prev   <= '0;
      ADATA0   <= '0;
      ADATARDY <= 1'b0;
    end else begin
      raw_v    <= last_bit;
      ADATARDY <= raw_v;
      if (last_bit) raw <= shift_nxt[23:6];
      if (raw_v) begin
        ADATA0 <= y_sat[YW-1:DC_SHIFT];
        x_prev <= raw;
        y_prev <= y_sat;
      end
      if (idle_entry) begin
        x_prev <= '0;
        y_prev <= '0;
      end
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (RST) begin
      ADATA0   <= '0;
      ADATARDY <= 1'b0;
    end else begin
      ADATARDY <= last_bit;
      if (last_bit) ADATA0 <= shift_nxt[23:6];
    end
  end
`endif

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench for i2s_mic_rx: mic model driving SD, frame-level reference model,
// per-cycle compare on both captured channels (two DUT instances).
module tb_i2s_mic_rx;
  localparam int SCK_DIV = 22;
  localparam int P       = 2 * SCK_DIV;
  localparam int FRAME   = 64 * P;
  localparam int DC      = 10;
`ifdef I2S_DCBLOCK_EN
  localparam int LX = 1;
`else
  localparam int LX = 0;
`endif
  localparam int OFF0 = 25 * P + LX;
  localparam int OFF1 = 57 * P + LX;

  // clock / reset
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic EN  = 1'b1;
  logic sd  = 1'b0;
  always #5 CLK = ~CLK;

  logic        sck0, ws0, rdy0, sck1, ws1, rdy1;
  logic [17:0] ad0, ad1;

  i2s_mic_rx #(.SCK_DIV(SCK_DIV), .CHANNEL(0), .DC_SHIFT(DC)) u_dut0 (
    .CLK(CLK), .RST(RST), .EN(EN), .I2S_SD(sd),
    .I2S_SCK(sck0), .I2S_WS(ws0), .ADATA0(ad0), .ADATARDY(rdy0)
  );
  i2s_mic_rx #(.SCK_DIV(SCK_DIV), .CHANNEL(1), .DC_SHIFT(DC)) u_dut1 (
    .CLK(CLK), .RST(RST), .EN(EN), .I2S_SD(sd),
    .I2S_SCK(sck1), .I2S_WS(ws1), .ADATA0(ad1), .ADATARDY(rdy1)
  );

  // scoreboard
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [17:0] exp_q[$];
  logic [17:0] exp1_q[$];
  logic [17:0] hold0 = '0;
  logic [17:0] hold1 = '0;
  bit          chk_en = 0;
  bit          m_active = 0;
  int          m_c = 0;
  int          n_rdy0 = 0;
  bit          force_en = 0;
  logic [23:0] force_l = '0;
  logic [23:0] force_r = '0;
  logic [23:0] wl = '0;
  logic [23:0] wr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event missing, expected it to occur", name);
  endtask

`ifdef I2S_DCBLOCK_EN
  longint fx[2];
  longint fy[2];

  function automatic logic [17:0] dc_model(input int ch, input logic [17:0] xr);
    longint x, acc, lim;
    x   = longint'($signed(xr));
    lim = longint'(131072) <<< DC;
    acc = ((x - fx[ch]) <<< DC) + fy[ch] - (fy[ch] >>> DC);
    if (acc > lim - 1) acc = lim - 1;
    if (acc < -lim)    acc = -lim;
    fx[ch] = x;
    fy[ch] = acc;
    return 18'(acc >>> DC);
  endfunction
`endif

  // Reference timeline: m_c counts CLKs since the current run began; a run
  // stops only at a frame boundary seen with EN low.
  always @(posedge CLK) begin
    if (RST) begin
      m_active = EN;
      m_c      = 0;
      hold0    = '0;
      hold1    = '0;
      exp_q.delete();
      exp1_q.delete();
`ifdef I2S_DCBLOCK_EN
      fx = '{0, 0}; fy = '{0, 0};
`endif
    end else if (!m_active) begin
      if (EN) begin
        m_active = 1;
        m_c      = 0;
      end
    end else if ((m_c % FRAME) == FRAME - 1 && !EN) begin
      m_active = 0;
`ifdef I2S_DCBLOCK_EN
      fx = '{0, 0}; fy = '{0, 0};
`endif
    end else begin
      m_c = m_c + 1;
    end
  end

  int          off, b, slot;
  logic [23:0] w;
  logic        e_sck, e_ws, e_r0, e_r1;

  // Mic model plus per-cycle compare.
  always @(negedge CLK) begin
    e_sck = 0; e_ws = 0; e_r0 = 0; e_r1 = 0;
    sd = 1'($urandom_range(0, 1));
    if (m_active) begin
      off = m_c % FRAME;
      if (off == 0) begin
        wl = force_en ? force_l : 24'($urandom());
        wr = force_en ? force_r : 24'($urandom());
`ifdef I2S_DCBLOCK_EN
        exp_q.push_back(dc_model(0, wl[23:6]));
        exp1_q.push_back(dc_model(1, wr[23:6]));
`else
        exp_q.push_back(wl[23:6]);
        exp1_q.push_back(wr[23:6]);
`endif
      end
      b    = off / P;
      slot = b % 32;
      w    = (b < 32) ? wl : wr;
      if (slot >= 1 && slot <= 24) sd = w[24 - slot];
      e_sck = (m_c % P) >= SCK_DIV;
      e_ws  = (b >= 32);
      e_r0  = (off == OFF0);
      e_r1  = (off == OFF1);
    end
    if (chk_en) begin
      check("sck0", sck0, e_sck);
      check("ws0", ws0, e_ws);
      check("sck1", sck1, e_sck);
      check("ws1", ws1, e_ws);
      check("rdy0", rdy0, e_r0);
      check("rdy1", rdy1, e_r1);
      if (e_r0) begin
        if (exp_q.size() == 0) fail_now("exp_q0_empty");
        else hold0 = exp_q.pop_front();
      end
      if (e_r1) begin
        if (exp1_q.size() == 0) fail_now("exp_q1_empty");
        else hold1 = exp1_q.pop_front();
      end
      check("adata0_ch0", ad0, hold0);
      check("adata0_ch1", ad1, hold1);
    end
    if (rdy0 === 1'b1) n_rdy0++;
  end

  // driver tasks
  task automatic do_reset();
    @(negedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK); #1;
    check("rst_sck", sck0, 1'b0);
    check("rst_ws", ws0, 1'b0);
    check("rst_adata_ch0", ad0, 18'h0);
    check("rst_adata_ch1", ad1, 18'h0);
    check("rst_rdy", rdy0, 1'b0);
    @(negedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic wait_rdy(input int which, input int limit, output int n);
    n = 0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge CLK); #1;
      if ((which == 0 && rdy0 === 1'b1) || (which == 1 && rdy1 === 1'b1)) begin
        n = k;
        break;
      end
    end
    if (n == 0) fail_now("wait_rdy_timeout");
  endtask

  task automatic wait_mc(input int target);
    bit hit;
    hit = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge CLK); #1;
      if (m_active && (m_c % FRAME) == target) begin
        hit = 1;
        break;
      end
    end
    if (!hit) fail_now("wait_mc_timeout");
  endtask

  int n;
  int cnt;

  initial begin
    RST = 1'b1;
    EN  = 1'b1;
    @(negedge CLK); #1;
    chk_en = 1;

    // Full-scale words on both slots; first strobe timing and period.
    force_en = 1; force_l = 24'h7FFFC0; force_r = 24'h800000;
    do_reset();
    wait_rdy(0, 2 * FRAME, n);
    check("first_strobe_lat", n, OFF0);
    check("left_fullscale", ad0, 18'h1FFFF);
    wait_rdy(1, 2 * FRAME, n);
    check("right_after_left", n, OFF1 - OFF0);
    check("right_negfull", ad1, 18'h20000);
    wait_rdy(0, 2 * FRAME, n);
    check("left_after_right", n, FRAME - (OFF1 - OFF0));
    wait_rdy(0, 2 * FRAME, n);
    check("strobe_period", n, FRAME);

    // Truncation boundary below bit 6.
    force_l = 24'h00003F;
    do_reset();
    wait_rdy(0, 2 * FRAME, n);
    check("trunc_3f", ad0, 18'h0);
    force_l = 24'h000040;
    do_reset();
    wait_rdy(0, 2 * FRAME, n);
    check("trunc_40", ad0, 18'h1);

    // Random words.
    force_en = 0;
    for (int i = 0; i < 3; i++) begin
      wait_rdy(0, 2 * FRAME, n);
      if (i > 0) check("rand_period", n, FRAME);
    end

    // Reset in the middle of left-slot capture.
    wait_mc(20 * P + 3);
    do_reset();
    wait_rdy(0, 2 * FRAME, n);
    check("after_abort_lat", n, OFF0);

    // EN drop at bitcnt 10: frame completes, then idle, then restart.
    wait_mc(10 * P + 5);
    EN = 1'b0;
    wait_rdy(0, 2 * FRAME, n);
    check("drain_strobe", n, OFF0 - (10 * P + 5));
    cnt = n_rdy0;
    repeat (2000) @(negedge CLK);
    #1;
    check("idle_sck", sck0, 1'b0);
    check("idle_ws", ws0, 1'b0);
    check("idle_no_strobe", n_rdy0, cnt);
    EN = 1'b1;
    wait_rdy(0, 2 * FRAME, n);
    check("restart_lat", n, OFF0 + 1);

    // EN bounce inside DRAIN: no gap, no restart.
    wait_mc(30 * P + 7);
    EN = 1'b0;
    repeat (200) @(negedge CLK);
    #1;
    EN = 1'b1;
    wait_rdy(0, 2 * FRAME, n);
    check("bounce_next", n, FRAME + OFF0 - (30 * P + 7) - 200);
    wait_rdy(0, 2 * FRAME, n);
    check("bounce_period", n, FRAME);

`ifdef I2S_DCBLOCK_EN
    // Constant input through the DC blocker.
    force_en = 1; force_l = 24'h100000; force_r = 24'h100000;
    do_reset();
    wait_rdy(0, 2 * FRAME, n);
    check("dc_first", ad0, 18'd16384);
    wait_rdy(0, 2 * FRAME, n);
    check("dc_second", ad0, 18'd16368);
`endif

    repeat (5) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
